// File: rtl/constraint_sampler_pkg.sv
// Shared types and constants for constraint_sampler.
// Contents: FSM state enum, LFSR width and Galois tap mask, candidate
// variable slice widths/offsets, and the single-step LFSR function.
package constraint_sampler_pkg;

  localparam int unsigned LFSR_W = 64;

  // Galois right-shift mask for x^64 + x^63 + x^61 + x^60 + 1 (bits 63,62,60,59)
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 64'hD800_0000_0000_0000;

  localparam int unsigned VAR0_W   = 13;
  localparam int unsigned VAR1_W   = 13;
  localparam int unsigned VAR2_W   = 14;
  localparam int unsigned VAR3_W   = 14;
  localparam int unsigned VAR4_W   = 8;

  localparam int unsigned VAR0_OFF = 0;
  localparam int unsigned VAR1_OFF = VAR0_OFF + VAR0_W;
  localparam int unsigned VAR2_OFF = VAR1_OFF + VAR1_W;
  localparam int unsigned VAR3_OFF = VAR2_OFF + VAR2_W;
  localparam int unsigned VAR4_OFF = VAR3_OFF + VAR3_W;

  typedef enum logic {
    IDLE   = 1'b0,
    SEARCH = 1'b1
  } state_e;

  // One Galois LFSR step: shift right, fold taps in when bit 0 falls out
  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
    lfsr_next = (s >> 1) ^ (s[0] ? LFSR_TAPS : '0);
  endfunction

endpackage

// File: rtl/sampler_fifo.sv
// First-word-fall-through FIFO for accepted samples.
// Ports: push/push_data write side, pop/pop_data read side (pop_data is
// valid whenever empty=0), full/empty status. DEPTH must be a power of two
// and at least 2. Storage is reset so pop_data reads zero after reset.
module sampler_fifo #(
  parameter int unsigned WIDTH = 62,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W:0]   wr_q;
  logic [PTR_W:0]   rd_q;

  // Pointers carry one wrap bit to tell full from empty
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (push && !full) begin
        mem_q[wr_q[PTR_W-1:0]] <= push_data;
        wr_q                   <= wr_q + (PTR_W+1)'(1);
      end
      if (pop && !empty) begin
        rd_q <= rd_q + (PTR_W+1)'(1);
      end
    end
  end

  assign empty    = (wr_q == rd_q);
  assign full     = (wr_q[PTR_W] != rd_q[PTR_W]) &&
                    (wr_q[PTR_W-1:0] == rd_q[PTR_W-1:0]);
  assign pop_data = mem_q[rd_q[PTR_W-1:0]];

endmodule

// File: rtl/constraint_sampler.sv
// Constraint sampler: drives LFSR candidates onto var_0..var_4 of an external
// combinational constraint checker, accepts candidates whose masked
// constraint bits are all 1, buffers them in a FWFT FIFO and streams them out
// over out_valid/out_ready.
// Ports: clk, rst_n; request side start/count/seed_load/seed/cons_mask;
// checker side var_0..var_4 (out), cons_in (in); stream side out_valid,
// out_ready, out_sample; status busy, done (pulse), fail (pulse).
// Optional: define CONSTRAINT_SAMPLER_STATS_EN to add stat_attempts,
// stat_rejects and stat_fail_mask outputs.
module constraint_sampler
  import constraint_sampler_pkg::*;
#(
  parameter int unsigned       NUM_CONS     = 8,
  parameter int unsigned       CAND_W       = 62,
  parameter int unsigned       FIFO_DEPTH   = 4,
  parameter int unsigned       MAX_ATTEMPTS = 65535,
  parameter logic [LFSR_W-1:0] SEED         = 64'h1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [7:0]          count,
  input  logic                seed_load,
  input  logic [LFSR_W-1:0]   seed,
  input  logic [NUM_CONS-1:0] cons_mask,
  output logic [VAR0_W-1:0]   var_0,
  output logic [VAR1_W-1:0]   var_1,
  output logic [VAR2_W-1:0]   var_2,
  output logic [VAR3_W-1:0]   var_3,
  output logic [VAR4_W-1:0]   var_4,
  input  logic [NUM_CONS-1:0] cons_in,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [CAND_W-1:0]   out_sample,
  output logic                busy,
  output logic                done,
  output logic                fail
`ifdef CONSTRAINT_SAMPLER_STATS_EN
  ,
  output logic [31:0]         stat_attempts,
  output logic [31:0]         stat_rejects,
  output logic [NUM_CONS-1:0] stat_fail_mask
`endif
);

  localparam int unsigned ATT_W = $clog2(MAX_ATTEMPTS + 1);

  state_e              state_q, state_d;
  logic [LFSR_W-1:0]   lfsr_q, lfsr_d;
  logic [NUM_CONS-1:0] mask_q, mask_d;
  logic [7:0]          rem_q, rem_d;
  logic [ATT_W-1:0]    att_q, att_d;
  logic                done_d, fail_d;
  logic                ok_c, push_c, eval_c, fifo_full, fifo_empty;

  // Candidate is acceptable when every masked constraint bit is 1
  assign ok_c = &(cons_in | ~mask_q);

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      lfsr_q  <= SEED;
      mask_q  <= '0;
      rem_q   <= '0;
      att_q   <= '0;
      done    <= 1'b0;
      fail    <= 1'b0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      mask_q  <= mask_d;
      rem_q   <= rem_d;
      att_q   <= att_d;
      done    <= done_d;
      fail    <= fail_d;
    end
  end

  // Next-state: a full FIFO with an acceptable candidate freezes the search
  always_comb begin
    state_d = state_q;
    lfsr_d  = lfsr_q;
    mask_d  = mask_q;
    rem_d   = rem_q;
    att_d   = att_q;
    done_d  = 1'b0;
    fail_d  = 1'b0;
    push_c  = 1'b0;
    eval_c  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          mask_d = cons_mask;
          rem_d  = count;
          att_d  = '0;
          if (seed_load) begin
            lfsr_d = (seed == '0) ? SEED : seed;
          end
          if (count == 8'd0) begin
            done_d = 1'b1;
          end else begin
            state_d = SEARCH;
          end
        end
      end
      SEARCH: begin
        if (!(ok_c && fifo_full)) begin
          eval_c = 1'b1;
          att_d  = att_q + ATT_W'(1);
          lfsr_d = lfsr_next(lfsr_q);
          if (ok_c) begin
            push_c = 1'b1;
            rem_d  = rem_q - 8'd1;
          end
          // Final accept takes priority over exhausting attempts
          if (ok_c && (rem_q == 8'd1)) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end else if (att_q == ATT_W'(MAX_ATTEMPTS - 1)) begin
            fail_d  = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy  = (state_q == SEARCH);
  assign var_0 = lfsr_q[VAR0_OFF +: VAR0_W];
  assign var_1 = lfsr_q[VAR1_OFF +: VAR1_W];
  assign var_2 = lfsr_q[VAR2_OFF +: VAR2_W];
  assign var_3 = lfsr_q[VAR3_OFF +: VAR3_W];
  assign var_4 = lfsr_q[VAR4_OFF +: VAR4_W];

  // Accepted-sample buffer; draining is independent of the FSM
  sampler_fifo #(
    .WIDTH (CAND_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push_c),
    .push_data (lfsr_q[CAND_W-1:0]),
    .pop       (out_ready),
    .pop_data  (out_sample),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign out_valid = !fifo_empty;

`ifdef CONSTRAINT_SAMPLER_STATS_EN
  // Saturating search statistics, cleared when a request is accepted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_attempts  <= '0;
      stat_rejects   <= '0;
      stat_fail_mask <= '0;
    end else if ((state_q == IDLE) && start) begin
      stat_attempts  <= '0;
      stat_rejects   <= '0;
      stat_fail_mask <= '0;
    end else if (eval_c) begin
      if (stat_attempts != '1) begin
        stat_attempts <= stat_attempts + 32'd1;
      end
      if (!ok_c) begin
        if (stat_rejects != '1) begin
          stat_rejects <= stat_rejects + 32'd1;
        end
        stat_fail_mask <= stat_fail_mask | (~cons_in & mask_q);
      end
    end
  end
`endif

endmodule

// File: tb/tb_constraint_sampler.sv
`timescale 1ns/1ps
module tb_constraint_sampler;

  localparam int unsigned NUM_CONS = 8;
  localparam int unsigned CAND_W   = 62;
  localparam int unsigned DEPTH    = 4;
  localparam int          MAX_ATT  = 16;
  localparam logic [63:0] SEED     = 64'h1;
  localparam logic [63:0] TAPS     = 64'hD800_0000_0000_0000;

  logic                clk;
  logic                rst_n;
  logic                start;
  logic [7:0]          count;
  logic                seed_load;
  logic [63:0]         seed;
  logic [NUM_CONS-1:0] cons_mask;
  logic [12:0]         var_0;
  logic [12:0]         var_1;
  logic [13:0]         var_2;
  logic [13:0]         var_3;
  logic [7:0]          var_4;
  logic [NUM_CONS-1:0] cons_in;
  logic                out_valid;
  logic                out_ready;
  logic [CAND_W-1:0]   out_sample;
  logic                busy;
  logic                done;
  logic                fail;

  int          chk_mode;
  int          n_cmp;
  int          n_bad;
  logic [63:0] m_lfsr;
  logic [61:0] exp_q[$];

  constraint_sampler #(
    .NUM_CONS     (NUM_CONS),
    .CAND_W       (CAND_W),
    .FIFO_DEPTH   (DEPTH),
    .MAX_ATTEMPTS (MAX_ATT),
    .SEED         (SEED)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .count      (count),
    .seed_load  (seed_load),
    .seed       (seed),
    .cons_mask  (cons_mask),
    .var_0      (var_0),
    .var_1      (var_1),
    .var_2      (var_2),
    .var_3      (var_3),
    .var_4      (var_4),
    .cons_in    (cons_in),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_sample (out_sample),
    .busy       (busy),
    .done       (done),
    .fail       (fail)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stand-in constraint checker: 0 = all satisfied, 1 = none, else var_0 ^ var_1
  function automatic logic [7:0] checker_fn(input int mode, input logic [61:0] c);
    case (mode)
      0:       return 8'hFF;
      1:       return 8'h00;
      default: return c[7:0] ^ c[20:13];
    endcase
  endfunction

  assign cons_in = checker_fn(chk_mode, {var_4, var_3, var_2, var_1, var_0});

  function automatic logic [63:0] step(input logic [63:0] s);
    return {1'b0, s[63:1]} ^ (s[0] ? TAPS : 64'h0);
  endfunction

  // Reference search: queues expected samples, returns evaluated cycles
  task automatic model_run(input int cnt, input logic [7:0] mask, input int mode,
                           output int evals, output bit fexp);
    int          rem;
    logic [61:0] c;
    bit          ok;
    rem   = cnt;
    evals = 0;
    fexp  = 1'b0;
    while (rem > 0) begin
      c      = m_lfsr[61:0];
      ok     = &(checker_fn(mode, c) | ~mask);
      m_lfsr = step(m_lfsr);
      evals++;
      if (ok) begin
        exp_q.push_back(c);
        rem--;
      end
      if (rem > 0 && evals == MAX_ATT) begin
        fexp = 1'b1;
        break;
      end
    end
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s act=%0h req=%0h", name, act, req);
    end
  endtask

  // Output monitor: a sample is consumed at the coming edge when valid&ready
  task automatic mon_check();
    logic [61:0] e;
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_sample", 64'(out_sample), 64'h0);
      end else begin
        e = exp_q.pop_front();
        chk("sample", 64'(out_sample), 64'(e));
      end
    end
  endtask

  task automatic tick();
    mon_check();
    @(posedge clk);
    #1;
  endtask

  // Waits (bounded) for done/fail; optionally pokes a start while searching
  task automatic wait_end(input int poke_k, output int seen_k, output bit gd,
                          output bit gf, output int busy_n);
    seen_k = -1;
    gd     = 1'b0;
    gf     = 1'b0;
    busy_n = 0;
    for (int k = 0; k < 200; k++) begin
      if (k == poke_k) begin
        start = 1'b1; count = 8'd1; seed_load = 1'b1; seed = 64'h55;
      end else begin
        start = 1'b0; seed_load = 1'b0;
      end
      if (done || fail) begin
        gd = done; gf = fail; seen_k = k;
        break;
      end
      if (busy) busy_n++;
      tick();
    end
    start = 1'b0;
    seed_load = 1'b0;
  endtask

  typedef struct {
    int          cnt;
    logic [7:0]  mask;
    int          mode;
    bit          sl;
    logic [63:0] sd;
    int          exp_res;  // 0 done, 1 fail, 2 from reference model
    int          exp_cyc;  // -1 from reference model
  } vec_t;

  vec_t vecs[7];

  task automatic run_vec(input int idx, input vec_t v);
    int evals, seen_k, busy_n, cyc;
    bit fexp, gd, gf, e_done, e_fail;
    chk_mode  = v.mode;
    count     = 8'(v.cnt);
    cons_mask = v.mask;
    seed_load = v.sl;
    seed      = v.sd;
    start     = 1'b1;
    if (v.sl) m_lfsr = (v.sd == 64'h0) ? SEED : v.sd;
    model_run(v.cnt, v.mask, v.mode, evals, fexp);
    tick();
    wait_end(-1, seen_k, gd, gf, busy_n);
    e_done = (v.exp_res == 2) ? !fexp : (v.exp_res == 0);
    e_fail = !e_done;
    cyc    = (v.exp_cyc < 0) ? evals : v.exp_cyc;
    chk($sformatf("v%0d_done", idx), 64'(gd), 64'(e_done));
    chk($sformatf("v%0d_fail", idx), 64'(gf), 64'(e_fail));
    chk($sformatf("v%0d_end_cycle", idx), 64'(seen_k), 64'(cyc));
    chk($sformatf("v%0d_busy_cycles", idx), 64'(busy_n), 64'(cyc));
    tick();
    chk($sformatf("v%0d_pulse_len", idx), 64'({done, fail, busy}), 64'h0);
    repeat (4) tick();
    chk($sformatf("v%0d_drained", idx), 64'(exp_q.size()), 64'h0);
  endtask

  initial begin
    int          evals, seen_k, busy_n;
    bit          fexp, gd, gf;
    logic [61:0] frozen;

    n_cmp = 0; n_bad = 0;
    chk_mode = 0; start = 1'b0; count = 8'd0; seed_load = 1'b0; seed = 64'h0;
    cons_mask = '0; out_ready = 1'b1; m_lfsr = SEED;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    repeat (2) tick();
    chk("rst_busy", 64'(busy), 64'h0);
    chk("rst_done_fail", 64'({done, fail}), 64'h0);
    chk("rst_out_valid", 64'(out_valid), 64'h0);
    chk("rst_out_sample", 64'(out_sample), 64'h0);
    chk("rst_vars", 64'({var_4, var_3, var_2, var_1, var_0}), 64'(SEED[61:0]));
    rst_n = 1'b1;
    tick();

    vecs[0] = '{4, 8'h00, 0, 1'b0, 64'h0, 0, 4};
    vecs[1] = '{1, 8'hFF, 1, 1'b0, 64'h0, 1, MAX_ATT};
    vecs[2] = '{0, 8'h00, 0, 1'b0, 64'h0, 0, 0};
    vecs[3] = '{2, 8'h00, 1, 1'b1, 64'h0, 0, 2};
    vecs[4] = '{3, 8'h03, 2, 1'b1, 64'hDEAD_BEEF_1234_5678, 2, -1};
    vecs[5] = '{8, 8'h80, 2, 1'b0, 64'h0, 2, -1};
    vecs[6] = '{3, 8'hFF, 0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 0, 3};
    for (int i = 0; i < 7; i++) run_vec(i, vecs[i]);

    // A start pulse while searching must not disturb the request
    chk_mode = 0; cons_mask = 8'h00; count = 8'd5; start = 1'b1;
    model_run(5, 8'h00, 0, evals, fexp);
    tick();
    wait_end(1, seen_k, gd, gf, busy_n);
    chk("ign_done", 64'(gd), 64'h1);
    chk("ign_end_cycle", 64'(seen_k), 64'd5);
    repeat (5) tick();
    chk("ign_drained", 64'(exp_q.size()), 64'h0);

    // Backpressure: FIFO fills after 4, search freezes on candidate 5
    out_ready = 1'b0; chk_mode = 0; cons_mask = 8'h00; count = 8'd6; start = 1'b1;
    model_run(6, 8'h00, 0, evals, fexp);
    frozen = exp_q[4];
    tick();
    start = 1'b0;
    repeat (5) tick();
    chk("stall_busy", 64'(busy), 64'h1);
    chk("stall_vars_a", 64'({var_4, var_3, var_2, var_1, var_0}), 64'(frozen));
    chk("stall_valid", 64'(out_valid), 64'h1);
    repeat (2) tick();
    chk("stall_vars_b", 64'({var_4, var_3, var_2, var_1, var_0}), 64'(frozen));
    chk("stall_done_held", 64'(done), 64'h0);
    out_ready = 1'b1;
    wait_end(-1, seen_k, gd, gf, busy_n);
    chk("stall_done", 64'(gd), 64'h1);
    repeat (6) tick();
    chk("stall_drained", 64'(exp_q.size()), 64'h0);

    // Asynchronous reset in the middle of a long search
    out_ready = 1'b0; chk_mode = 0; cons_mask = 8'h00; count = 8'd10; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (2) tick();
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", 64'(busy), 64'h0);
    chk("mid_rst_valid", 64'(out_valid), 64'h0);
    chk("mid_rst_sample", 64'(out_sample), 64'h0);
    chk("mid_rst_vars", 64'({var_4, var_3, var_2, var_1, var_0}), 64'(SEED[61:0]));
    exp_q.delete();
    m_lfsr = SEED;
    repeat (2) tick();
    rst_n = 1'b1;
    out_ready = 1'b1;
    tick();
    chk("post_rst_vars", 64'({var_4, var_3, var_2, var_1, var_0}), 64'(SEED[61:0]));
    chk("post_rst_state", 64'({busy, out_valid, done, fail}), 64'h0);
    run_vec(7, vecs[0]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/constraint_sampler.md
Name: constraint_sampler

Overview:
- Drives candidate assignments into a generated constraint-checker module and collects the assignments that satisfy the constraints.
- The checker is instantiated alongside and is purely combinational: var_0..var_4 in, constraint_0..constraint_7 out.
- Candidates come from a 64-bit LFSR. Accepted samples are buffered in a FIFO and streamed out over a valid/ready interface.
- The block is the generator/consumer end of the checker's var/constraint interface.

Parameters:
- NUM_CONS, 8, number of constraint bits returned by the checker.
- CAND_W, 62, total candidate width (13+13+14+14+8).
- FIFO_DEPTH, 4, accepted-sample buffer depth; power of two, at least 2.
- MAX_ATTEMPTS, 65535, candidates evaluated per request before failing; at least 1.
- SEED, 64'h1, LFSR value at reset and replacement for a zero seed.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request pulse; accepted only in IDLE
- count  in  8  number of samples requested
- seed_load  in  1  qualifies seed with start
- seed  in  64  LFSR seed
- cons_mask  in  NUM_CONS  constraint bits that must be 1; sampled at start
- var_0  out  13  candidate bits [12:0]
- var_1  out  13  candidate bits [25:13]
- var_2  out  14  candidate bits [39:26]
- var_3  out  14  candidate bits [53:40]
- var_4  out  8  candidate bits [61:54]
- cons_in  in  NUM_CONS  constraint_0..constraint_7 from the checker, bit i = constraint_i
- out_valid  out  1  sample available
- out_ready  in  1  downstream accept
- out_sample  out  CAND_W  accepted candidate
- busy  out  1  high in SEARCH
- done  out  1  one-cycle pulse when count samples are pushed
- fail  out  1  one-cycle pulse on attempt exhaustion

Behaviour:
- Reset values:
  - state IDLE; LFSR = SEED; var_* = SEED[61:0] slices.
  - busy, done, fail, out_valid = 0; FIFO empty; out_sample = 0.
- Reset mid-search aborts the request. FIFO contents are discarded.
- Candidate path:
  - var_* are the LFSR state register bits [61:0], with no combinational path from inputs.
  - cons_in is evaluated in the same cycle.
  - ok = &(cons_in | ~mask_q).
- LFSR: Galois, polynomial x^64+x^63+x^61+x^60+1. It advances one step per evaluated cycle.
- IDLE:
  - On start, latch mask_q = cons_mask and rem = count, and clear attempts.
  - If seed_load=1, LFSR = seed; a zero seed is replaced by SEED.
  - If count=0: pulse done next cycle and stay in IDLE. Otherwise go to SEARCH.
- SEARCH, per cycle:
  - If ok and the FIFO is full: stall. The LFSR and attempts are held and the candidate is re-evaluated next cycle.
  - Otherwise the cycle is an evaluated cycle: attempts += 1 and the LFSR advances.
  - If ok and not full: push the candidate and rem -= 1.
  - If rem reaches 0: pulse done and go to IDLE.
  - If instead attempts reaches MAX_ATTEMPTS with rem>0: pulse fail and go to IDLE. Success wins when the final attempt is also the final accept.
- start while busy is ignored.
- FIFO:
  - First-word fall-through; out_sample is valid whenever out_valid=1.
  - A simultaneous push and pop when full is not allowed (a full FIFO stalls the push).
  - A simultaneous push and pop when empty passes the sample through with one cycle of latency.
  - Draining continues after return to IDLE.
- Latency: the first candidate is evaluated in the cycle after start is accepted. A sample accepted in cycle N has out_valid=1 in cycle N+1.

Optional Feature:
- Macro: CONSTRAINT_SAMPLER_STATS_EN.
- With the macro defined:
  - Adds outputs stat_attempts [31:0] and stat_rejects [31:0], both cleared on start.
  - stat_attempts counts evaluated cycles; stat_rejects counts evaluated cycles with ok=0. Both saturate.
  - Adds output stat_fail_mask [NUM_CONS-1:0]: the OR of ~cons_in & mask_q over rejected cycles.
- Without the macro: these ports and registers are absent.

Decomposition:
- Package constraint_sampler_pkg:
  - state enum (IDLE, SEARCH).
  - LFSR width and tap constant.
  - var slice widths and offsets.
  - lfsr_next function.
- Sub-module sampler_fifo: FWFT FIFO parameterised by width and depth, with full, empty, push and pop ports.

Test Plan:
- cons_mask=0, SEED=1, count=4, out_ready=1 → 4 samples on 4 consecutive cycles equal to the LFSR sequence after seed 1; done pulse 4 cycles after start; busy high for exactly 4 cycles.
- cons_in tied 0, mask=8'hFF, MAX_ATTEMPTS=16, count=1 → fail pulse 16 cycles after start; out_valid never asserted; state IDLE.
- mask=0, FIFO_DEPTH=4, count=6, out_ready=0 → 4 pushes, then stall with var_* frozen and busy=1; raise out_ready → remaining 2 pushed, done pulse, 6 samples received in order.
- count=0 → done pulse and no samples; start asserted during SEARCH → ignored, rem unchanged.
- rst_n low in the middle of a count=10 search → all outputs reach reset values immediately; the FIFO is empty and var_* = SEED slices after release.
- seed_load=1 with seed=0 → LFSR loaded with SEED, with no lock-up at zero.
